wb_ext_resp: RTL
================

Name: wb_ext_resp

Overview:
- Wishbone slave that forwards each bus access to an external host (testbench or debug harness) over a simple request/response port, and returns the host's reply on the bus.
- It is the responder counterpart of the wb_ext initiator: wb_ext lets the host master the bus, while this block lets bus masters (CPU, wb_ext) target host-emulated peripherals.
- It hangs off a free wb_mux slave slot and adds a timeout so a silent host cannot hang the CPU.

Parameters:
- WB_DATA_WIDTH, 32, data bus width.
- WB_ADDR_WIDTH, 32, address bus width.
- WB_SEL_WIDTH, 4, byte-select width (WB_DATA_WIDTH/8).
- TIMEOUT_CYCLES, 1024, number of PENDING cycles before an auto-reply; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- wb_addr_i  in  WB_ADDR_WIDTH  bus address.
- wb_data_i  in  WB_DATA_WIDTH  write data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  WB_SEL_WIDTH  byte selects.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge, single-cycle pulse.
- wb_data_o  out  WB_DATA_WIDTH  read data.
- req_valid_o  out  1  request pending to the host.
- req_addr_o  out  WB_ADDR_WIDTH  latched address.
- req_data_o  out  WB_DATA_WIDTH  latched write data.
- req_sel_o  out  WB_SEL_WIDTH  latched byte selects.
- req_we_o  out  1  latched write enable.
- req_size_o  out  2  decoded from sel: 0 = byte, 1 = half, 2 = word, 3 = illegal (same encoding as wb_ext).
- resp_valid_i  in  1  host response strobe; sampled only while req_valid_o is 1.
- resp_data_i  in  WB_DATA_WIDTH  host read data; don't-care for writes.
- timeout_o  out  1  sticky flag: a timeout occurred.
- illegal_o  out  1  sticky flag: an illegal sel pattern was seen.
- flags_clear_i  in  1  clears both sticky flags.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0; latches 0; timeout counter 0.
- States: IDLE, PENDING, ACK.
- IDLE, on cyc & stb at a clock edge:
  - Latch addr, data, sel and we.
  - Legal sel (0001, 0010, 0100, 1000, 0011, 1100, 1111): go to PENDING. req_valid_o rises the next cycle, with req_* stable until it falls.
  - Illegal sel: go directly to ACK with wb_data_o = 0, and set illegal_o.
- PENDING, at each clock edge, in priority order:
  1. !wb_cyc_i (master abort): go to IDLE. req_valid_o drops and any concurrent resp_valid_i is ignored; no ack is issued.
  2. resp_valid_i: latch resp_data_i into wb_data_o (zero it for writes) and go to ACK.
  3. Counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0: set wb_data_o = TIMEOUT_DATA (0 for writes), set timeout_o, go to ACK.
  4. Otherwise increment the counter.
- A response that arrives in the same cycle as the timeout wins; timeout_o is not set.
- ACK:
  - wb_ack_o = 1 for exactly one cycle and req_valid_o = 0; then go to IDLE.
  - wb_data_o holds its value until the next capture.
- Latency: bus request to req_valid_o is 1 cycle; resp_valid_i to wb_ack_o is 1 cycle. The minimum transaction is 3 cycles.
- The counter resets to 0 on every entry to PENDING. It has width clog2(TIMEOUT_CYCLES)+1 and never wraps.
- No new capture occurs in the ACK cycle; back-to-back accesses resume from IDLE.
- Sticky flags:
  - flags_clear_i clears both flags next cycle.
  - If set and clear coincide, set wins.
- Async reset mid-transaction: immediate return to IDLE; req_valid_o and wb_ack_o drop asynchronously.

Test Plan:
- Word read: addr=0x0003_0010, sel=1111, we=0; host raises resp_valid_i 5 cycles after req_valid_o with 0x1234_5678 → req_size_o=2; wb_ack_o pulses once, 1 cycle after resp, with wb_data_o=0x1234_5678.
- Byte write: sel=0100, data=0x00AB_0000 → req_we_o=1, req_size_o=0, req_data_o=0x00AB_0000; resp_valid_i → ack next cycle, wb_data_o=0.
- Timeout: TIMEOUT_CYCLES=8, no response → ack on the 9th cycle after req_valid_o rises, wb_data_o=0xDEAD_BEEF, timeout_o=1; flags_clear_i → timeout_o=0.
- Resp/timeout collision: resp_valid_i asserted exactly on the timeout cycle with 0x5 → wb_data_o=0x5, timeout_o stays 0.
- Abort and illegal sel: wb_cyc_i dropped in PENDING → no ack, req_valid_o=0 next cycle, a later resp is ignored. Separately, sel=0110 → ack in 2 cycles, data 0, illegal_o=1, req_valid_o never rises.
- Reset mid-PENDING: rst_i pulsed → all outputs 0 immediately; a following word read completes normally.

Source files
------------

// File: rtl/wb_ext_resp.sv
// Wishbone slave that hands each bus access to an external host over a
// request/response port, with a timeout auto-reply and sticky error flags.
module wb_ext_resp #(
  parameter int                       WB_DATA_WIDTH  = 32,
  parameter int                       WB_ADDR_WIDTH  = 32,
  parameter int                       WB_SEL_WIDTH   = 4,
  parameter int                       TIMEOUT_CYCLES = 1024,
  parameter logic [WB_DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     req_valid_o,
  output logic [WB_ADDR_WIDTH-1:0] req_addr_o,
  output logic [WB_DATA_WIDTH-1:0] req_data_o,
  output logic [WB_SEL_WIDTH-1:0]  req_sel_o,
  output logic                     req_we_o,
  output logic [1:0]               req_size_o,
  input  logic                     resp_valid_i,
  input  logic [WB_DATA_WIDTH-1:0] resp_data_i,
  output logic                     timeout_o,
  output logic                     illegal_o,
  input  logic                     flags_clear_i
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam bit                TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_ACK     = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic [WB_ADDR_WIDTH-1:0] r_addr;
  logic [WB_DATA_WIDTH-1:0] r_wdata;
  logic [WB_DATA_WIDTH-1:0] r_rdata;
  logic [WB_SEL_WIDTH-1:0]  r_sel;
  logic                     r_we;
  logic [1:0]               r_size;
  logic                     r_timeout;
  logic                     r_illegal;

  logic [3:0]               w_sel4;
  logic [1:0]               w_size;
  logic                     w_capture;
  logic                     w_illegal;
  logic                     w_take_resp;
  logic                     w_take_to;

  // Size encoding shared with wb_ext: 0 byte, 1 half, 2 word, 3 illegal.
  always_comb begin
    w_sel4 = 4'(wb_sel_i);
    case (w_sel4)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
      4'b0011, 4'b1100:                   w_size = 2'd1;
      4'b1111:                            w_size = 2'd2;
      default:                            w_size = 2'd3;
    endcase
  end

  assign w_capture = (r_state == S_IDLE) && wb_cyc_i && wb_stb_i;
  assign w_illegal = w_capture && (w_size == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_next      = r_state;
    w_take_resp = 1'b0;
    w_take_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_next = w_illegal ? S_ACK : S_PENDING;
      end
      S_PENDING: begin
        if (!wb_cyc_i) begin
          w_next = S_IDLE;
        end else if (resp_valid_i) begin
          w_take_resp = 1'b1;
          w_next      = S_ACK;
        end else if (TO_EN && (r_cnt == CNT_LAST)) begin
          w_take_to = 1'b1;
          w_next    = S_ACK;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_size    <= 2'd0;
      r_timeout <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr  <= wb_addr_i;
        r_wdata <= wb_data_i;
        r_sel   <= wb_sel_i;
        r_we    <= wb_we_i;
        r_size  <= w_size;
        r_cnt   <= '0;
        if (w_illegal) r_rdata <= '0;
      end
      // Writes always return zero data, whether answered or timed out.
      if (w_take_resp) begin
        r_rdata <= r_we ? '0 : resp_data_i;
      end else if (w_take_to) begin
        r_rdata <= r_we ? '0 : TIMEOUT_DATA;
      end else if ((r_state == S_PENDING) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Set beats a coincident clear.
      if (w_take_to)          r_timeout <= 1'b1;
      else if (flags_clear_i) r_timeout <= 1'b0;
      if (w_illegal)          r_illegal <= 1'b1;
      else if (flags_clear_i) r_illegal <= 1'b0;
    end
  end

  assign req_valid_o = (r_state == S_PENDING);
  assign wb_ack_o    = (r_state == S_ACK);
  assign wb_data_o   = r_rdata;
  assign req_addr_o  = r_addr;
  assign req_data_o  = r_wdata;
  assign req_sel_o   = r_sel;
  assign req_we_o    = r_we;
  assign req_size_o  = r_size;
  assign timeout_o   = r_timeout;
  assign illegal_o   = r_illegal;

endmodule
